// File: rtl/pipe_ctrl_pkg.sv
// ============================================================
// pipe_ctrl_pkg : shared constants and state encoding for pipe_ctrl
// Rev 1.0
// ============================================================
`default_nettype none

package pipe_ctrl_pkg;

    localparam int unsigned RV32_ADDR_WIDTH    = 32;
    localparam logic [RV32_ADDR_WIDTH-1:0] RST_INST_ADDR = 32'h0000_0080;
    localparam int unsigned MD_TIMEOUT_DEFAULT = 64;
    localparam int unsigned MD_CNT_WIDTH       = 8;

    localparam logic [1:0] PIPE_ST_IDLE    = 2'd0;
    localparam logic [1:0] PIPE_ST_FLUSH   = 2'd1;
    localparam logic [1:0] PIPE_ST_MD_WAIT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = PIPE_ST_IDLE,
        ST_FLUSH   = PIPE_ST_FLUSH,
        ST_MD_WAIT = PIPE_ST_MD_WAIT
    } pipe_state_e;

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
// ============================================================
// pipe_ctrl_if : EX-stage events in, stage-wide stall/flush/redirect out
// Rev 1.0
// ============================================================
`default_nettype none

interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic                       jump_en_i;
    logic [RV32_ADDR_WIDTH-1:0] jump_addr_i;
    logic                       muldiv_start_i;
    logic                       muldiv_done_i;
    logic                       ext_hold_i;
    logic                       pipeline_stall_o;
    logic                       pipeline_flush_o;
    logic                       pc_redirect_o;
    logic [RV32_ADDR_WIDTH-1:0] pc_redirect_addr_o;
    logic                       md_timeout_o;

    modport master (
        input  jump_en_i, jump_addr_i, muldiv_start_i, muldiv_done_i, ext_hold_i,
        output pipeline_stall_o, pipeline_flush_o, pc_redirect_o,
               pc_redirect_addr_o, md_timeout_o
    );

    modport slave (
        output jump_en_i, jump_addr_i, muldiv_start_i, muldiv_done_i, ext_hold_i,
        input  pipeline_stall_o, pipeline_flush_o, pc_redirect_o,
               pc_redirect_addr_o, md_timeout_o
    );

endinterface

`default_nettype wire

// File: rtl/dff_rs_ld.sv
// ============================================================
// dff_rs_ld : loadable register with asynchronous active-low reset value
// Rev 1.0
// ============================================================
`default_nettype none

module dff_rs_ld #(
    parameter int unsigned      WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             ld_i,
    input  wire logic [WIDTH-1:0] d_i,
    output logic      [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= RST_VAL;
        end else if (ld_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl_perf_cnt.sv
// ============================================================
// pipe_perf_cnt : 32-bit wrapping event counter with increment enable
// Rev 1.0
// ============================================================
`default_nettype none

module pipe_perf_cnt (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        inc_i,
    input  wire logic        load_i,
    input  wire logic [31:0] load_val_i,
    output logic      [31:0] cnt_o
);

    logic [31:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 32'd0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (inc_i) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================
// pipe_ctrl : pipeline stall/flush/redirect controller
// Optional: PIPE_CTRL_PERF_CNT_EN adds stall/flush performance counters
// Rev 1.0
// ============================================================
`default_nettype none

module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MD_TIMEOUT = MD_TIMEOUT_DEFAULT
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    pipe_ctrl_if.master ctrl
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);

    localparam logic [MD_CNT_WIDTH-1:0] MD_LAST = MD_CNT_WIDTH'(MD_TIMEOUT - 1);

    pipe_state_e             state_q;
    logic                    flush_q;
    logic                    redirect_q;
    logic                    md_timeout_q;
    logic [MD_CNT_WIDTH-1:0] md_cnt_q;

    logic jump_take;
    logic md_take;
    logic stall;

    assign jump_take = (state_q == ST_IDLE) && ctrl.jump_en_i && !ctrl.ext_hold_i;
    assign md_take   = (state_q == ST_IDLE) && ctrl.muldiv_start_i && !ctrl.jump_en_i
                       && !ctrl.ext_hold_i;

    // The cycle that hits MD_LAST still stalls; the abort shows up as the pulse next cycle.
    assign stall = ctrl.ext_hold_i
                 | ((state_q == ST_IDLE)    && ctrl.muldiv_start_i && !ctrl.jump_en_i)
                 | ((state_q == ST_MD_WAIT) && !ctrl.muldiv_done_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            flush_q      <= 1'b0;
            redirect_q   <= 1'b0;
            md_timeout_q <= 1'b0;
            md_cnt_q     <= '0;
        end else begin
            md_timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (jump_take) begin
                        state_q    <= ST_FLUSH;
                        flush_q    <= 1'b1;
                        redirect_q <= 1'b1;
                    end else if (md_take) begin
                        state_q  <= ST_MD_WAIT;
                        md_cnt_q <= '0;
                    end
                end
                ST_FLUSH: begin
                    if (!ctrl.ext_hold_i) begin
                        state_q    <= ST_IDLE;
                        flush_q    <= 1'b0;
                        redirect_q <= 1'b0;
                    end
                end
                ST_MD_WAIT: begin
                    md_cnt_q <= md_cnt_q + MD_CNT_WIDTH'(1);
                    if (ctrl.muldiv_done_i) begin
                        state_q <= ST_IDLE;
                    end else if (md_cnt_q == MD_LAST) begin
                        state_q      <= ST_IDLE;
                        md_timeout_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    flush_q    <= 1'b0;
                    redirect_q <= 1'b0;
                end
            endcase
        end
    end

    dff_rs_ld #(
        .WIDTH   (RV32_ADDR_WIDTH),
        .RST_VAL (RST_INST_ADDR)
    ) u_redirect_addr (
        .clk   (clk),
        .rst_n (rst_n),
        .ld_i  (jump_take),
        .d_i   (ctrl.jump_addr_i),
        .q_o   (ctrl.pc_redirect_addr_o)
    );

    assign ctrl.pipeline_stall_o = stall;
    assign ctrl.pipeline_flush_o = flush_q;
    assign ctrl.pc_redirect_o    = redirect_q;
    assign ctrl.md_timeout_o     = md_timeout_q;

`ifdef PIPE_CTRL_PERF_CNT_EN
    pipe_perf_cnt u_stall_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_i      (stall),
        .load_i     (1'b0),
        .load_val_i (32'd0),
        .cnt_o      (stall_cnt_o)
    );

    pipe_perf_cnt u_flush_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_i      (jump_take),
        .load_i     (1'b0),
        .load_val_i (32'd0),
        .cnt_o      (flush_cnt_o)
    );
`endif

endmodule

`default_nettype wire
